// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
//
// Streams a program into instruction memory over a valid/ready word
// interface, then hands control to the core through a level run-enable.
//
//   IDLE  --load_req-->  LOAD  --last word-->  FLUSH  --> RUN  --stop--> IDLE
//                          |                     |
//                          +--addr overflow--> ERR <--checksum mismatch
//
// Each accepted word is written to memory one cycle after the handshake.
// FLUSH is the single cycle in which the final write lands, before o_start
// goes high.
//
// Optional feature: define PROG_LOADER_CHECKSUM_EN to XOR every accepted
// word into an accumulator and compare it against i_checksum in FLUSH.
// Without the macro, i_checksum is ignored and FLUSH always enters RUN.
// ----------------------------------------------------------------------------
module prog_loader #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  // control
  input  logic              load_req,
  input  logic              stop,

  // program word stream
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic [DATA_W-1:0] i_checksum,

  // instruction-memory write port
  output logic [DATA_W-1:0] o_instruction,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wea,

  // core control and status
  output logic              o_start,
  output logic [ADDR_W:0]   o_words,
  output logic [31:0]       run_cnt,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [31:0]       RUN_MAX  = '1;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_cnt;     // index the next accepted word will use
  logic              accept;       // word handshake completes this cycle
  logic              start_load;   // a new load begins this cycle
  logic              checksum_ok;  // FLUSH may proceed to RUN

  // A load starts only from a resting state; stop wins over load_req.
  assign start_load = load_req && !stop && (state == ST_IDLE || state == ST_ERR);

  // s_ready already folds in LOAD and the stop abort.
  assign accept = s_valid && s_ready;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_acc;

  // Running XOR of every accepted word, cleared at the start of each load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_acc <= '0;
    end else if (start_load) begin
      checksum_acc <= '0;
    end else if (accept) begin
      checksum_acc <= checksum_acc ^ s_data;
    end
  end

  // The final word is already folded in by the time the FSM is in FLUSH.
  assign checksum_ok = (checksum_acc == i_checksum);
`else
  logic unused_checksum;

  // i_checksum has no function in this build; reduce it to a named sink.
  assign unused_checksum = ^i_checksum;
  assign checksum_ok     = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of block ordering.
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_load) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (accept) begin
          if (s_last)                    state_nxt = ST_FLUSH;
          else if (addr_cnt == ADDR_MAX) state_nxt = ST_ERR;
        end
      end
      ST_FLUSH: begin
        // stop is deliberately ignored here: the final write is in flight.
        state_nxt = checksum_ok ? ST_RUN : ST_ERR;
      end
      ST_RUN: begin
        if (stop) state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        if (start_load) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    s_ready = 1'b0;
    o_start = 1'b0;
    busy    = 1'b0;
    err     = 1'b0;
    unique case (state)
      ST_IDLE:  ;
      ST_LOAD:  begin
        // A stop pulse aborts the load, so the word offered with it is
        // refused rather than accepted and then dropped.
        s_ready = !stop;
        busy    = 1'b1;
      end
      ST_FLUSH: busy    = 1'b1;
      ST_RUN:   o_start = 1'b1;
      ST_ERR:   err     = 1'b1;
      default:  ;
    endcase
  end

  // Memory write port: one-cycle registered copy of each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_wea         <= 1'b0;
      o_instruction <= '0;
      o_addr        <= '0;
    end else begin
      o_wea <= accept;
      if (accept) begin
        o_instruction <= s_data;
        o_addr        <= addr_cnt;
      end
    end
  end

  // Address counter: saturates at the top so an overflowing load never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
    end else if (start_load) begin
      addr_cnt <= '0;
    end else if (accept && addr_cnt != ADDR_MAX) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  // Written-word count: steps on the same edge that raises o_wea.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_words <= '0;
    end else if (start_load) begin
      o_words <= '0;
    end else if (accept) begin
      o_words <= o_words + (ADDR_W+1)'(1);
    end
  end

  // RUN cycle counter: saturating, held outside RUN, cleared by a new load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (start_load) begin
      run_cnt <= '0;
    end else if (state == ST_RUN && run_cnt != RUN_MAX) begin
      run_cnt <= run_cnt + 32'd1;
    end
  end

endmodule
